chip_test_sequencer: RTL and testbench

- Top-level controller for the chip-checker testers; one tester per supported part (e.g. 7402 quad NOR).
- Uses the user's chip select to launch the matching tester, runs it NUM_PASSES times back-to-back and collects its pass/fail result.
- Clears each tester through its display handshake, then holds a single verdict for the display/LED logic until the user acknowledges it.

---
 rtl/chip_test_sequencer.sv | 175 +++++++++++++++++
 tb/tb_chip_test_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_test_sequencer.sv
// Chip-checker top controller: runs the selected tester NUM_PASSES times and holds one verdict.
// Optional per-run watchdog is built when CHIP_SEQ_TIMEOUT_EN is defined.
module chip_test_sequencer #(
   parameter int unsigned NUM_CHIPS   = 8,
   parameter int unsigned SEL_W       = 3,
   parameter int unsigned NUM_PASSES  = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [SEL_W-1:0]     Chip_Sel,
   input  logic                 Disp_Ack,
   input  logic [NUM_CHIPS-1:0] Chip_Done,
   input  logic [NUM_CHIPS-1:0] Chip_RSLT,
   output logic [NUM_CHIPS-1:0] Chip_Run,
   output logic [NUM_CHIPS-1:0] Chip_Disp,
   output logic                 Busy,
   output logic                 Result_Valid,
   output logic                 Pass,
   output logic                 Sel_Err,
   output logic                 Timeout,
   output logic [7:0]           Pass_Cnt,
   output logic [SEL_W-1:0]     Active_Sel
);

   typedef enum logic [2:0] {
      StIdle, StLaunch, StWaitDone, StSample, StRelease, StNext, StReport
   } state_e;

   localparam logic [NUM_CHIPS-1:0] SlotLsb    = NUM_CHIPS'(1);
   localparam logic [SEL_W:0]       NumChipsW  = NUM_CHIPS[SEL_W:0];
   localparam logic [7:0]           NumPassesB = NUM_PASSES[7:0];

   if ((2 ** SEL_W) < NUM_CHIPS || NUM_PASSES == 0 || NUM_PASSES > 255 || TIMEOUT_CYC == 0)
   begin : g_bad_params
      $error("chip_test_sequencer: illegal parameter combination");
   end

   state_e                 state_q, state_d;
   logic                   start_q, start_edge;
   logic                   sel_bad, done_sel, tmo_hit;
   logic                   rslt_q, rslt_d;
   logic [7:0]             cnt_inc, cnt_d;
   logic [SEL_W-1:0]       sel_d;
   logic [NUM_CHIPS-1:0]   run_d, disp_d, mask_d;
   logic                   busy_d, valid_d, pass_d, err_d, tmo_d;

   assign start_edge = Start & ~start_q;
   assign sel_bad    = ({1'b0, Chip_Sel} >= NumChipsW);
   assign done_sel   = Chip_Done[Active_Sel];
   assign cnt_inc    = (Pass_Cnt == 8'hFF) ? Pass_Cnt : Pass_Cnt + 8'd1;

`ifdef CHIP_SEQ_TIMEOUT_EN
   localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

   logic [TmoW-1:0] tmo_cnt_q;
   logic            waiting;

   assign waiting = (state_q == StWaitDone) || (state_q == StSample);
   assign tmo_hit = waiting && (tmo_cnt_q == TmoLast);

   // Held at zero outside the wait states, so every WAIT_DONE entry from LAUNCH starts fresh.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)       tmo_cnt_q <= '0;
      else if (waiting) tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
      else              tmo_cnt_q <= '0;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= StIdle;
         start_q      <= 1'b0;
         rslt_q       <= 1'b0;
         Chip_Run     <= '0;
         Chip_Disp    <= '0;
         Busy         <= 1'b0;
         Result_Valid <= 1'b0;
         Pass         <= 1'b0;
         Sel_Err      <= 1'b0;
         Timeout      <= 1'b0;
         Pass_Cnt     <= '0;
         Active_Sel   <= '0;
      end else begin
         state_q      <= state_d;
         start_q      <= Start;
         rslt_q       <= rslt_d;
         Chip_Run     <= run_d;
         Chip_Disp    <= disp_d;
         Busy         <= busy_d;
         Result_Valid <= valid_d;
         Pass         <= pass_d;
         Sel_Err      <= err_d;
         Timeout      <= tmo_d;
         Pass_Cnt     <= cnt_d;
         Active_Sel   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (start_edge) state_d = sel_bad ? StReport : StLaunch;
         StLaunch:   state_d = StWaitDone;
         StWaitDone: begin
            if (tmo_hit)       state_d = StReport;
            else if (done_sel) state_d = StSample;
         end
         // Done must be seen on two consecutive cycles before RSLT is trusted.
         StSample: begin
            if (tmo_hit) state_d = StReport;
            else         state_d = done_sel ? StRelease : StWaitDone;
         end
         StRelease:  if (!done_sel) state_d = StNext;
         StNext:     state_d = (!rslt_q || cnt_inc == NumPassesB) ? StReport : StLaunch;
         StReport:   if (Disp_Ack) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      sel_d  = Active_Sel;
      cnt_d  = Pass_Cnt;
      pass_d = Pass;
      err_d  = Sel_Err;
      tmo_d  = Timeout;
      rslt_d = rslt_q;
      run_d  = '0;
      disp_d = '0;
      unique case (state_q)
         StIdle: begin
            if (start_edge) begin
               sel_d  = Chip_Sel;
               cnt_d  = '0;
               pass_d = 1'b0;
               err_d  = sel_bad;
               tmo_d  = 1'b0;
            end
         end
         StSample: if (!tmo_hit && done_sel) rslt_d = Chip_RSLT[Active_Sel];
         StNext: begin
            if (rslt_q) begin
               cnt_d = cnt_inc;
               if (cnt_inc == NumPassesB) pass_d = 1'b1;
            end else begin
               pass_d = 1'b0;
            end
         end
         StReport: begin
            if (Disp_Ack) begin
               pass_d = 1'b0;
               err_d  = 1'b0;
               tmo_d  = 1'b0;
            end
         end
         default: ;
      endcase
      mask_d = SlotLsb << sel_d;
      // A hung tester still gets one DISP pulse so it is cleared before the verdict.
      if (tmo_hit) begin
         tmo_d  = 1'b1;
         pass_d = 1'b0;
         disp_d = mask_d;
      end
      if (state_d == StLaunch)  run_d  = mask_d;
      if (state_d == StRelease) disp_d = mask_d;
      busy_d  = (state_d != StIdle) && (state_d != StReport);
      valid_d = (state_d == StReport);
   end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Self-checking bench for chip_test_sequencer: vector table, random runs against a verdict model,
// and hand-written handshake, Start-filter and reset sequences.
module tb_chip_test_sequencer;
   localparam int unsigned NC = 5;
   localparam int unsigned SW = 3;
   localparam int unsigned NP = 4;
   localparam int unsigned TO = 64;

   logic          Clk = 1'b0;
   logic          Reset, Start, Disp_Ack;
   logic [SW-1:0] Chip_Sel;
   logic [NC-1:0] Chip_Done, Chip_RSLT, Chip_Run, Chip_Disp;
   logic          Busy, Result_Valid, Pass, Sel_Err, Timeout;
   logic [7:0]    Pass_Cnt;
   logic [SW-1:0] Active_Sel;

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   chip_test_sequencer #(
      .NUM_CHIPS   (NC),
      .SEL_W       (SW),
      .NUM_PASSES  (NP),
      .TIMEOUT_CYC (TO)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Start        (Start),
      .Chip_Sel     (Chip_Sel),
      .Disp_Ack     (Disp_Ack),
      .Chip_Done    (Chip_Done),
      .Chip_RSLT    (Chip_RSLT),
      .Chip_Run     (Chip_Run),
      .Chip_Disp    (Chip_Disp),
      .Busy         (Busy),
      .Result_Valid (Result_Valid),
      .Pass         (Pass),
      .Sel_Err      (Sel_Err),
      .Timeout      (Timeout),
      .Pass_Cnt     (Pass_Cnt),
      .Active_Sel   (Active_Sel)
   );

   typedef struct {
      int         sel;
      logic [3:0] pat;     // bit k = RSLT of run k
      int         delay;
      bit         noisy;
      int         e_pass;
      int         e_cnt;
      int         e_launch;
      int         e_err;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int all_outs();
      return int'({Chip_Run, Chip_Disp, Busy, Result_Valid, Pass, Sel_Err, Timeout, Pass_Cnt,
                   Active_Sel});
   endfunction

   // Verdict from the rules: stop at the first failing run, pass after NP good runs.
   function automatic void model(input int sel, input logic [3:0] pat, output int pass,
                                 output int cnt, output int launches, output int err);
      pass = 0; cnt = 0; launches = 0;
      err = (sel >= int'(NC)) ? 1 : 0;
      if (err != 0) return;
      for (int k = 0; k < int'(NP); k++) begin
         launches++;
         if (!pat[k]) return;
         cnt++;
      end
      pass = 1;
   endfunction

   task automatic run_seq(input string tag, input int sel, input logic [3:0] pat, input int delay,
                          input bit noisy, input int e_pass, input int e_cnt, input int e_launch,
                          input int e_err);
      logic [NC-1:0] mask;
      int launches = 0, cyc = 0, cnt_down = 0, done_cyc = 0;
      bit tbusy = 0, tdone = 0, bad = 0, got = 0;
      mask = NC'(32'd1 << sel);
      @(negedge Clk);
      Chip_Sel = SW'(sel);
      Start = 1'b1;
      while (!got && cyc < 600) begin
         @(negedge Clk);
         cyc++;
         Start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         if ((Chip_Run & ~mask) != 0 || (Chip_Disp & ~mask) != 0) bad = 1;
         if (Chip_Run != 0 && Chip_Disp != 0) bad = 1;
         if ((Chip_Run & mask) != 0 && (tbusy || tdone)) bad = 1;
         if ((Chip_Disp & mask) != 0 && !tdone) bad = 1;
         if (Result_Valid == Busy) bad = 1;
         if (Result_Valid) begin
            got = 1;
         end else begin
            if (!tbusy && !tdone && (Chip_Run & mask) != 0) begin
               tbusy = 1; cnt_down = delay; launches++;
            end else if (tbusy) begin
               cnt_down--;
               if (cnt_down <= 0) begin tbusy = 0; tdone = 1; done_cyc = 0; end
            end else if (tdone && (Chip_Disp & mask) != 0) begin
               tdone = 0;
            end else if (tdone) begin
               done_cyc++;
            end
            // First Done cycle carries an unsettled (inverted) RSLT, like the real testers.
            Chip_Done = (NC'($urandom) & ~mask) | (tdone ? mask : '0);
            Chip_RSLT = (NC'($urandom) & ~mask) |
                        ((tdone && ((done_cyc > 0) == pat[(launches - 1) & 3])) ? mask : '0);
         end
      end
      check({tag, " report reached"}, int'(got), 1);
      check({tag, " pass"}, int'(Pass), e_pass);
      check({tag, " pass_cnt"}, int'(Pass_Cnt), e_cnt);
      check({tag, " launches"}, launches, e_launch);
      check({tag, " sel_err"}, int'(Sel_Err), e_err);
      check({tag, " active_sel"}, int'(Active_Sel), sel);
      check({tag, " timeout"}, int'(Timeout), 0);
      check({tag, " handshake"}, int'(bad), 0);
      if (e_err != 0) check({tag, " sel_err latency ok"}, int'(cyc <= 2), 1);
      Chip_Done = '0;
      Chip_RSLT = '0;
      Start = 1'b0;
      if (noisy) @(negedge Clk);
      Disp_Ack = 1'b1;
      if (noisy) Start = 1'b1;   // same-cycle Start must be dropped
      @(negedge Clk);
      Disp_Ack = 1'b0;
      check({tag, " ack clears"}, int'({Result_Valid, Pass, Sel_Err, Busy}), 0);
      check({tag, " cnt kept"}, int'(Pass_Cnt), e_cnt);
      if (noisy) begin
         bad = 0;
         repeat (4) begin
            @(negedge Clk);
            if (Busy || Result_Valid || Chip_Run != 0) bad = 1;
         end
         check({tag, " no retrigger"}, int'(bad), 0);
         Start = 1'b0;
      end
   endtask

   initial begin
      int p, c, l, e, disp_cnt, cyc;
      Reset = 1'b0; Start = 1'b0; Disp_Ack = 1'b0; Chip_Sel = '0;
      Chip_Done = '0; Chip_RSLT = '0;
      vecs[0] = '{sel: 2, pat: 4'b1111, delay: 10, noisy: 0, e_pass: 1, e_cnt: 4, e_launch: 4, e_err: 0};
      vecs[1] = '{sel: 2, pat: 4'b1011, delay: 10, noisy: 0, e_pass: 0, e_cnt: 2, e_launch: 3, e_err: 0};
      vecs[2] = '{sel: 6, pat: 4'b1111, delay: 3,  noisy: 0, e_pass: 0, e_cnt: 0, e_launch: 0, e_err: 1};
      vecs[3] = '{sel: 0, pat: 4'b0000, delay: 1,  noisy: 0, e_pass: 0, e_cnt: 0, e_launch: 1, e_err: 0};
      vecs[4] = '{sel: 4, pat: 4'b1111, delay: 3,  noisy: 1, e_pass: 1, e_cnt: 4, e_launch: 4, e_err: 0};
      vecs[5] = '{sel: 7, pat: 4'b0101, delay: 2,  noisy: 1, e_pass: 0, e_cnt: 0, e_launch: 0, e_err: 1};
      vecs[6] = '{sel: 1, pat: 4'b0111, delay: 2,  noisy: 0, e_pass: 0, e_cnt: 3, e_launch: 4, e_err: 0};
      vecs[7] = '{sel: 3, pat: 4'b1101, delay: 5,  noisy: 1, e_pass: 0, e_cnt: 1, e_launch: 2, e_err: 0};

      repeat (2) @(negedge Clk);
      check("reset outputs zero", all_outs(), 0);
      Reset = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < 8; i++)
         run_seq($sformatf("vec%0d", i), vecs[i].sel, vecs[i].pat, vecs[i].delay, vecs[i].noisy,
                 vecs[i].e_pass, vecs[i].e_cnt, vecs[i].e_launch, vecs[i].e_err);

      for (int i = 0; i < 20; i++) begin
         int sel, dly;
         logic [3:0] pat;
         bit nz;
         sel = $urandom_range(0, 7);
         pat = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) pat = 4'hF;
         dly = $urandom_range(1, 12);
         nz  = 1'($urandom_range(0, 1));
         model(sel, pat, p, c, l, e);
         run_seq($sformatf("rnd%0d", i), sel, pat, dly, nz, p, c, l, e);
      end

      // Done glitch is ignored; long Done holds Disp; RSLT taken from the second Done cycle.
      @(negedge Clk);
      Chip_Sel = 3'd1; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check("hs run pulse", int'(Chip_Run), 2);
      repeat (3) @(negedge Clk);
      Chip_Done = 5'b00010; Chip_RSLT = 5'b00010;
      @(negedge Clk);
      Chip_Done = '0; Chip_RSLT = '0;
      disp_cnt = 0;
      repeat (4) begin
         @(negedge Clk);
         if (Chip_Disp != 0 || Chip_Run != 0) disp_cnt++;
      end
      check("hs glitch ignored", disp_cnt, 0);
      check("hs still busy", int'(Busy), 1);
      Chip_Done = 5'b00010; Chip_RSLT = 5'b00010;
      disp_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         if (Chip_Disp == 5'b00010) disp_cnt++;
         Chip_RSLT = '0;
      end
      Chip_Done = '0;
      check("hs disp held", disp_cnt, 4);
      @(negedge Clk);
      check("hs disp falls", int'(Chip_Disp), 0);
      cyc = 0;
      while (!Result_Valid && cyc < 10) begin @(negedge Clk); cyc++; end
      check("hs report", int'(Result_Valid), 1);
      check("hs second-cycle rslt", int'({Pass, Pass_Cnt}), 0);
      Disp_Ack = 1'b1;
      @(negedge Clk);
      Disp_Ack = 1'b0;
      check("hs back idle", int'(Result_Valid), 0);

      // Reset asserted in WAIT_DONE clears everything without a clock edge.
      @(negedge Clk);
      Chip_Sel = 3'd2; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      check("pre-reset busy", int'(Busy), 1);
      #2 Reset = 1'b0;
      #1 check("async reset outputs", all_outs(), 0);
      @(negedge Clk);
      check("held reset outputs", all_outs(), 0);
      Reset = 1'b1;
      run_seq("post-reset", 2, 4'hF, 4, 0, 1, 4, 4, 0);

`ifdef CHIP_SEQ_TIMEOUT_EN
      @(negedge Clk);
      Chip_Sel = 3'd3; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      cyc = 0;
      while (!Result_Valid && cyc < 200) begin @(negedge Clk); cyc++; end
      check("tmo report", int'(Result_Valid), 1);
      check("tmo flag", int'({Timeout, Pass}), 2);
      check("tmo latency ok", int'(cyc >= 63 && cyc <= 67), 1);
      check("tmo disp pulse", int'(Chip_Disp), 8);
      Disp_Ack = 1'b1;
      @(negedge Clk);
      Disp_Ack = 1'b0;
      check("tmo cleared", int'({Timeout, Result_Valid, Chip_Disp}), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
